ex_ctrl: RTL and testbench
==========================

# ex_ctrl

Execute-stage sequencing controller. Generates the stall, flush and bubble controls around the execute stage for three cases:
- load-use hazards
- taken branches and jumps resolved in EX
- multi-cycle EX operations, such as an iterative mul/div unit, through a start/done handshake with a timeout.

It sits beside the ID/EX and EX/MEM pipeline registers and is the single source of their enable and clear controls.

## Interface
Parameters:
- REG_ADDR_W, 5, register index width
- MC_MAX_CYCLES, 64, multi-cycle timeout limit (≥2)
- CNT_W, 32, stall performance-counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID
- id_rs1_used, id_rs2_used  in  1  the source is actually read
- ex_rd  in  REG_ADDR_W  destination of the instruction in EX
- ex_rf_en  in  1  EX instruction writes the register file
- ex_is_load  in  1  EX instruction is a load
- ex_br_taken  in  1  branch taken or jump, from the control-flow unit
- ex_mc_op  in  1  EX instruction is multi-cycle
- mc_done  in  1  multi-cycle unit result valid (1-cycle pulse)
- mc_start  out  1  start pulse to the multi-cycle unit
- mc_abort  out  1  timeout pulse
- if_stall, id_stall, ex_stall  out  1  hold the PC, IF/ID and ID/EX registers
- if_flush  out  1  clear IF/ID
- id_flush  out  1  insert a bubble into ID/EX
- mem_bubble  out  1  insert a bubble into EX/MEM
- stall_cnt  out  CNT_W  saturating count of cycles with if_stall=1

## Operation
- FSM has two states: RUN and MC_WAIT. Reset enters RUN.
- **RUN**, evaluated in priority order:
  1. ex_mc_op=1: mc_start=1, if/id/ex_stall=1, mem_bubble=1. Next state MC_WAIT.
  2. ex_br_taken=1: if_flush=1, id_flush=1, no stall. A load-use condition detected in the same cycle is ignored, because the younger instruction is being killed.
  3. Load-use, defined as ex_is_load & ex_rf_en & ex_rd≠0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)): if_stall=1, id_stall=1, id_flush=1. Exactly one bubble is inserted per hazard.
  4. Otherwise all controls are 0.
- **MC_WAIT**:
  - mc_done=0: if/id/ex_stall=1, mem_bubble=1, mc_start=0. The load-use and branch inputs are ignored.
  - mc_done=1: all controls drop in the same cycle so EX/MEM captures the result. Next state RUN.
  - Timeout: the wait counter reaches MC_MAX_CYCLES-1 with mc_done=0. mc_abort=1, the pipeline releases exactly as for done, next state RUN. mc_done and the timeout in the same cycle are treated as done, with no abort.
- Wait counter:
  - Cleared on entry to MC_WAIT.
  - Increments each MC_WAIT cycle.
  - Width is $clog2(MC_MAX_CYCLES).
- mc_done while in RUN is ignored.
- stall_cnt:
  - Increments when if_stall=1.
  - Saturates at all-ones with no wrap.
  - Cleared only by reset.

## Timing
- All stall, flush, bubble and mc_* outputs are combinational (Mealy) from the state and the current inputs. State, wait counter and stall_cnt are registered.
- Reset values: state RUN, counters 0. During the reset cycle every output is forced to 0.
- A load-use hazard costs 1 stall cycle.
- A branch costs 2 flushed slots and 0 stall cycles.
- A multi-cycle op with mc_done arriving k cycles after mc_start (k≥1) holds the pipeline for k cycles:
  - the start cycle plus k-1 MC_WAIT cycles with mc_done=0
  - then the done cycle, which releases the pipeline
- mc_start is high for exactly one cycle per multi-cycle instruction.
- Back-to-back multi-cycle instructions: the second mc_start fires in the cycle immediately after the first instruction's done cycle.
- rst_n deasserted mid-MC_WAIT: the next cycle is RUN with counters 0 and no mc_abort. The multi-cycle unit is reset by the same rst_n.

## Configuration
- Macro EX_CTRL_MC_EN.
- Defined: the multi-cycle support described above is built.
- Undefined:
  - MC_WAIT and the wait counter are not built; the FSM is permanently RUN.
  - ex_mc_op and mc_done are ignored; mc_start=0 and mc_abort=0.
  - ex_stall=0 and mem_bubble=0 always.
  - Load-use and branch behaviour is unchanged.

## Structure
- Package ex_ctrl_pkg:
  - ex_ctrl_state_t enum {RUN, MC_WAIT}
  - struct ex_ctrl_out_t grouping the stall, flush and bubble outputs
- Sub-module hzd_detect: purely combinational load-use comparator producing a single lu_hazard bit, reused by future ID-stage forwarding checks.

## Test plan
- Load x5 in EX; ID instruction reads x5 as rs2 with id_rs2_used=1 → exactly 1 cycle of if_stall=id_stall=id_flush=1, then 0; stall_cnt=1.
- Load with ex_rd=0 against id_rs1=0 → no stall. Same case with id_rs1_used=0 → no stall.
- ex_br_taken=1 together with a load-use match → if_flush=id_flush=1, if_stall=0, stall_cnt unchanged.
- ex_mc_op=1, mc_done 4 cycles after mc_start → mc_start for 1 cycle, ex_stall high for 4 cycles, mem_bubble low in the done cycle; a second ex_mc_op then starts on the next cycle.
- MC_MAX_CYCLES=8, mc_done never asserted → mc_abort pulses in the 8th cycle after mc_start and the FSM returns to RUN. With mc_done in that same cycle → no abort.
- rst_n=0 in the 3rd MC_WAIT cycle → next cycle RUN, all outputs 0, stall_cnt=0. Build with EX_CTRL_MC_EN undefined → ex_mc_op=1 produces no stall.

Source files
------------

// File: rtl/ex_ctrl_pkg.sv
// Shared types for the execute-stage sequencing controller.
package ex_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } ex_ctrl_state_t;

  // Pipeline-register controls driven by ex_ctrl.
  typedef struct packed {
    logic if_stall;
    logic id_stall;
    logic ex_stall;
    logic if_flush;
    logic id_flush;
    logic mem_bubble;
  } ex_ctrl_out_t;

  localparam ex_ctrl_out_t CTL_IDLE = '0;

  // Freeze PC, IF/ID and ID/EX; keep EX/MEM fed with bubbles.
  function automatic ex_ctrl_out_t ctl_mc_hold();
    ex_ctrl_out_t c;
    c            = CTL_IDLE;
    c.if_stall   = 1'b1;
    c.id_stall   = 1'b1;
    c.ex_stall   = 1'b1;
    c.mem_bubble = 1'b1;
    return c;
  endfunction

  // Kill the two younger instructions in IF/ID and ID/EX.
  function automatic ex_ctrl_out_t ctl_branch();
    ex_ctrl_out_t c;
    c          = CTL_IDLE;
    c.if_flush = 1'b1;
    c.id_flush = 1'b1;
    return c;
  endfunction

  // Hold IF/ID for one cycle and send a bubble into EX.
  function automatic ex_ctrl_out_t ctl_load_use();
    ex_ctrl_out_t c;
    c          = CTL_IDLE;
    c.if_stall = 1'b1;
    c.id_stall = 1'b1;
    c.id_flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/ex_ctrl_hzd_detect.sv
// Load-use comparator: flags an ID-stage read of a register that the load
// currently in EX has not yet produced. Purely combinational.
module hzd_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  rf_en,
  input  logic                  is_load,
  output logic                  lu_hazard
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit   = rs1_used && (rs1 == rd);
  assign rs2_hit   = rs2_used && (rs2 == rd);
  // x0 is hardwired, so a load targeting it never creates a dependency.
  assign lu_hazard = is_load && rf_en && (rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/ex_ctrl.sv
// Execute-stage sequencing controller: stall/flush/bubble generation for
// load-use hazards, taken branches and multi-cycle EX operations.
// Multi-cycle support is built only when EX_CTRL_MC_EN is defined.
//
// Multi-cycle handshake: mc_start is a one-cycle request issued in the first
// cycle the op sits in EX. The unit answers with a one-cycle mc_done pulse;
// there is no backpressure in either direction. If no mc_done arrives by the
// last allowed wait cycle, mc_abort pulses once, telling the unit to drop the
// op, and the pipeline is released as though the op had completed.
module ex_ctrl
  import ex_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W    = 5,
  parameter int MC_MAX_CYCLES = 64,
  parameter int CNT_W         = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_rf_en,
  input  logic                  ex_is_load,
  input  logic                  ex_br_taken,
  input  logic                  ex_mc_op,
  input  logic                  mc_done,
  output logic                  mc_start,
  output logic                  mc_abort,
  output logic                  if_stall,
  output logic                  id_stall,
  output logic                  ex_stall,
  output logic                  if_flush,
  output logic                  id_flush,
  output logic                  mem_bubble,
  output logic [CNT_W-1:0]      stall_cnt
);

  logic             lu_hazard;
  ex_ctrl_out_t     ctl;
  ex_ctrl_out_t     ctl_g;
  logic             mc_start_c;
  logic             mc_abort_c;
  logic [CNT_W-1:0] stall_cnt_q;

  hzd_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hzd_detect (
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .rs1_used (id_rs1_used),
    .rs2_used (id_rs2_used),
    .rd       (ex_rd),
    .rf_en    (ex_rf_en),
    .is_load  (ex_is_load),
    .lu_hazard(lu_hazard)
  );

`ifdef EX_CTRL_MC_EN
  localparam int WAIT_W = $clog2(MC_MAX_CYCLES);

  ex_ctrl_state_t    state_q;
  ex_ctrl_state_t    state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              timeout;

  assign timeout = (wait_cnt_q == WAIT_W'(MC_MAX_CYCLES - 1));

  // State register and wait counter; the counter idles at 0 in RUN so it
  // enters MC_WAIT cleared, and counts every MC_WAIT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == RUN) begin
        wait_cnt_q <= '0;
      end else begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
    end
  end

  // Next state and Mealy controls; RUN priority is mc op, branch, load-use.
  always_comb begin
    state_d    = state_q;
    ctl        = CTL_IDLE;
    mc_start_c = 1'b0;
    mc_abort_c = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_mc_op) begin
          ctl        = ctl_mc_hold();
          mc_start_c = 1'b1;
          state_d    = MC_WAIT;
        end else if (ex_br_taken) begin
          ctl = ctl_branch();
        end else if (lu_hazard) begin
          ctl = ctl_load_use();
        end
      end
      MC_WAIT: begin
        // Done wins over a coincident timeout; both release the pipeline
        // in this cycle so EX/MEM captures whatever EX presents.
        if (mc_done) begin
          state_d = RUN;
        end else if (timeout) begin
          mc_abort_c = 1'b1;
          state_d    = RUN;
        end else begin
          ctl = ctl_mc_hold();
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end
`else
  logic mc_unused;

  assign mc_unused  = ex_mc_op ^ mc_done ^ (MC_MAX_CYCLES < 2);
  assign mc_start_c = 1'b0;
  assign mc_abort_c = 1'b0;

  // Permanently in RUN: only branch flushes and load-use stalls exist.
  always_comb begin
    ctl = CTL_IDLE;
    if (ex_br_taken) begin
      ctl = ctl_branch();
    end else if (lu_hazard) begin
      ctl = ctl_load_use();
    end
  end
`endif

  // All controls read as 0 while reset is held.
  assign ctl_g      = rst_n ? ctl : CTL_IDLE;
  assign if_stall   = ctl_g.if_stall;
  assign id_stall   = ctl_g.id_stall;
  assign ex_stall   = ctl_g.ex_stall;
  assign if_flush   = ctl_g.if_flush;
  assign id_flush   = ctl_g.id_flush;
  assign mem_bubble = ctl_g.mem_bubble;
  assign mc_start   = rst_n && mc_start_c;
  assign mc_abort   = rst_n && mc_abort_c;
  assign stall_cnt  = rst_n ? stall_cnt_q : '0;

  // Saturating count of front-end stall cycles; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (ctl_g.if_stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_ctrl.sv
// Directed bench for ex_ctrl. Multi-cycle scenarios are compiled in when
// EX_CTRL_MC_EN is defined; otherwise the disabled-feature behaviour is checked.
module tb_ex_ctrl;

  localparam int RW  = 5;
  localparam int MCM = 8;
  localparam int CW  = 4;

  // Packed view: {if_stall,id_stall,ex_stall,if_flush,id_flush,mem_bubble,mc_start,mc_abort}
  localparam logic [7:0] C_NONE  = 8'b0000_0000;
  localparam logic [7:0] C_LU    = 8'b1100_1000;
  localparam logic [7:0] C_BR    = 8'b0001_1000;
  localparam logic [7:0] C_MCS   = 8'b1110_0110;
  localparam logic [7:0] C_MCW   = 8'b1110_0100;
  localparam logic [7:0] C_ABORT = 8'b0000_0001;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_rs1_used, id_rs2_used, ex_rf_en, ex_is_load;
  logic          ex_br_taken, ex_mc_op, mc_done;
  logic          mc_start, mc_abort, if_stall, id_stall, ex_stall;
  logic          if_flush, id_flush, mem_bubble;
  logic [CW-1:0] stall_cnt;

  int            tests_run    = 0;
  int            tests_failed = 0;
  logic [CW-1:0] exp_cnt      = '0;

  ex_ctrl #(
    .REG_ADDR_W   (RW),
    .MC_MAX_CYCLES(MCM),
    .CNT_W        (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used),
    .ex_rd      (ex_rd),
    .ex_rf_en   (ex_rf_en),
    .ex_is_load (ex_is_load),
    .ex_br_taken(ex_br_taken),
    .ex_mc_op   (ex_mc_op),
    .mc_done    (mc_done),
    .mc_start   (mc_start),
    .mc_abort   (mc_abort),
    .if_stall   (if_stall),
    .id_stall   (id_stall),
    .ex_stall   (ex_stall),
    .if_flush   (if_flush),
    .id_flush   (id_flush),
    .mem_bubble (mem_bubble),
    .stall_cnt  (stall_cnt)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  function automatic logic [7:0] ctl_vec();
    return {if_stall, id_stall, ex_stall, if_flush, id_flush, mem_bubble, mc_start, mc_abort};
  endfunction

  // Driver tasks
  task automatic drive_idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rf_en = 1'b0; ex_is_load = 1'b0;
    ex_br_taken = 1'b0; ex_mc_op = 1'b0; mc_done = 1'b0;
  endtask

  task automatic drive_load(input logic [RW-1:0] rd, input logic [RW-1:0] rs1, input logic u1,
                            input logic [RW-1:0] rs2, input logic u2);
    drive_idle();
    ex_is_load = 1'b1; ex_rf_en = 1'b1; ex_rd = rd;
    id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
  endtask

  // Advance one clock; the expected stall count follows the expected if_stall.
  task automatic tick(input bit stalled);
    @(posedge clk);
    if (stalled && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    ex_br_taken = 1'b1; ex_mc_op = 1'b1;
    @(negedge clk);
    tests_run++;
    if (ctl_vec() !== C_NONE) begin tests_failed++; $display("FAIL reset_ctl: got %b exp %b", ctl_vec(), C_NONE); end
    tick(1'b0);
    @(negedge clk);
    tests_run++;
    if (stall_cnt !== '0) begin tests_failed++; $display("FAIL reset_cnt: got %0d exp 0", stall_cnt); end
    tick(1'b0);
    drive_idle();
    rst_n = 1'b1;
    exp_cnt = '0;
    @(negedge clk);
    tests_run++;
    if (ctl_vec() !== C_NONE) begin tests_failed++; $display("FAIL reset_idle: got %b exp %b", ctl_vec(), C_NONE); end
    tick(1'b0);
  endtask

  task automatic test_load_use();
    drive_load(5'd5, 5'd3, 1'b1, 5'd5, 1'b1);
    @(negedge clk);
    tests_run++;
    if (ctl_vec() !== C_LU) begin tests_failed++; $display("FAIL lu_rs2: got %b exp %b", ctl_vec(), C_LU); end
    tests_run++;
    if (stall_cnt !== 4'd0) begin tests_failed++; $display("FAIL lu_cnt_before: got %0d exp 0", stall_cnt); end
    tick(1'b1);
    drive_idle();
    @(negedge clk);
    tests_run++;
    if (ctl_vec() !== C_NONE) begin tests_failed++; $display("FAIL lu_release: got %b exp %b", ctl_vec(), C_NONE); end
    tests_run++;
    if (stall_cnt !== 4'd1) begin tests_failed++; $display("FAIL lu_cnt_after: got %0d exp 1", stall_cnt); end
    tick(1'b0);
    drive_load(5'd17, 5'd17, 1'b1, 5'd2, 1'b0);
    @(negedge clk);
    tests_run++;
    if (ctl_vec() !== C_LU) begin tests_failed++; $display("FAIL lu_rs1: got %b exp %b", ctl_vec(), C_LU); end
    tick(1'b1);
    drive_idle();
    tick(1'b0);
  endtask

  task automatic test_no_hazard();
    logic [RW-1:0] v_rd [4] = '{5'd0, 5'd7, 5'd9, 5'd12};
    logic [RW-1:0] v_rs [4] = '{5'd0, 5'd7, 5'd9, 5'd12};
    logic          v_use[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic          v_ld [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic          v_wr [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive_load(v_rd[i], v_rs[i], v_use[i], 5'd31, 1'b0);
      ex_is_load = v_ld[i];
      ex_rf_en   = v_wr[i];
      @(negedge clk);
      tests_run++;
      if (ctl_vec() !== C_NONE) begin tests_failed++; $display("FAIL no_hazard_%0d: got %b exp %b", i, ctl_vec(), C_NONE); end
      tick(1'b0);
    end
    drive_idle();
  endtask

  task automatic test_branch();
    drive_load(5'd8, 5'd8, 1'b1, 5'd8, 1'b1);
    ex_br_taken = 1'b1;
    @(negedge clk);
    tests_run++;
    if (ctl_vec() !== C_BR) begin tests_failed++; $display("FAIL br_over_lu: got %b exp %b", ctl_vec(), C_BR); end
    tick(1'b0);
    drive_idle();
    @(negedge clk);
    tests_run++;
    if (stall_cnt !== exp_cnt) begin tests_failed++; $display("FAIL br_cnt: got %0d exp %0d", stall_cnt, exp_cnt); end
    tick(1'b0);
  endtask

`ifdef EX_CTRL_MC_EN
  task automatic test_mc_op();
    drive_idle();
    ex_mc_op = 1'b1;
    @(negedge clk);
    tests_run++;
    if (ctl_vec() !== C_MCS) begin tests_failed++; $display("FAIL mc_start_cycle: got %b exp %b", ctl_vec(), C_MCS); end
    tick(1'b1);
    for (int i = 1; i < 4; i++) begin
      ex_br_taken = i[0];
      @(negedge clk);
      tests_run++;
      if (ctl_vec() !== C_MCW) begin tests_failed++; $display("FAIL mc_wait_%0d: got %b exp %b", i, ctl_vec(), C_MCW); end
      tick(1'b1);
    end
    ex_br_taken = 1'b0;
    mc_done = 1'b1;
    @(negedge clk);
    tests_run++;
    if (ctl_vec() !== C_NONE) begin tests_failed++; $display("FAIL mc_done_release: got %b exp %b", ctl_vec(), C_NONE); end
    tick(1'b0);
    mc_done = 1'b0;
    @(negedge clk);
    tests_run++;
    if (ctl_vec() !== C_MCS) begin tests_failed++; $display("FAIL mc_back_to_back: got %b exp %b", ctl_vec(), C_MCS); end
    tick(1'b1);
    mc_done = 1'b1;
    @(negedge clk);
    tests_run++;
    if (ctl_vec() !== C_NONE) begin tests_failed++; $display("FAIL mc_k1_done: got %b exp %b", ctl_vec(), C_NONE); end
    tick(1'b0);
    drive_idle();
    @(negedge clk);
    tests_run++;
    if (stall_cnt !== exp_cnt) begin tests_failed++; $display("FAIL mc_cnt: got %0d exp %0d", stall_cnt, exp_cnt); end
    tick(1'b0);
  endtask

  // with_done=0: no mc_done ever, abort in the 8th cycle after start.
  // with_done=1: mc_done lands in that same cycle, no abort.
  task automatic test_timeout(input bit with_done);
    drive_idle();
    ex_mc_op = 1'b1;
    @(negedge clk);
    tests_run++;
    if (ctl_vec() !== C_MCS) begin tests_failed++; $display("FAIL to%0d_start: got %b exp %b", with_done, ctl_vec(), C_MCS); end
    tick(1'b1);
    for (int i = 1; i < MCM; i++) begin
      @(negedge clk);
      tests_run++;
      if (ctl_vec() !== C_MCW) begin tests_failed++; $display("FAIL to%0d_wait_%0d: got %b exp %b", with_done, i, ctl_vec(), C_MCW); end
      tick(1'b1);
    end
    mc_done = with_done;
    @(negedge clk);
    tests_run++;
    if (ctl_vec() !== (with_done ? C_NONE : C_ABORT)) begin
      tests_failed++;
      $display("FAIL to%0d_end: got %b exp %b", with_done, ctl_vec(), (with_done ? C_NONE : C_ABORT));
    end
    tick(1'b0);
    drive_idle();
    ex_br_taken = 1'b1;
    @(negedge clk);
    tests_run++;
    if (ctl_vec() !== C_BR) begin tests_failed++; $display("FAIL to%0d_back_in_run: got %b exp %b", with_done, ctl_vec(), C_BR); end
    tick(1'b0);
    drive_idle();
  endtask

  task automatic test_reset_mid_wait();
    drive_idle();
    ex_mc_op = 1'b1;
    tick(1'b1);
    tick(1'b1);
    tick(1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if (ctl_vec() !== C_NONE) begin tests_failed++; $display("FAIL rst_wait_ctl: got %b exp %b", ctl_vec(), C_NONE); end
    tick(1'b0);
    exp_cnt = '0;
    rst_n = 1'b1;
    ex_mc_op = 1'b0;
    ex_br_taken = 1'b1;
    @(negedge clk);
    tests_run++;
    if (ctl_vec() !== C_BR) begin tests_failed++; $display("FAIL rst_wait_run: got %b exp %b", ctl_vec(), C_BR); end
    tests_run++;
    if (stall_cnt !== 4'd0) begin tests_failed++; $display("FAIL rst_wait_cnt: got %0d exp 0", stall_cnt); end
    tick(1'b0);
    drive_idle();
  endtask
`else
  task automatic test_mc_disabled();
    drive_idle();
    ex_mc_op = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mc_done = (i == 2);
      @(negedge clk);
      tests_run++;
      if (ctl_vec() !== C_NONE) begin tests_failed++; $display("FAIL mc_disabled_%0d: got %b exp %b", i, ctl_vec(), C_NONE); end
      tick(1'b0);
    end
    drive_idle();
    @(negedge clk);
    tests_run++;
    if (stall_cnt !== exp_cnt) begin tests_failed++; $display("FAIL mc_disabled_cnt: got %0d exp %0d", stall_cnt, exp_cnt); end
    tick(1'b0);
  endtask
`endif

  task automatic test_saturation();
    drive_load(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b1);
    drive_idle();
    @(negedge clk);
    tests_run++;
    if (stall_cnt !== exp_cnt) begin tests_failed++; $display("FAIL sat_model: got %0d exp %0d", stall_cnt, exp_cnt); end
    tests_run++;
    if (stall_cnt !== 4'hF) begin tests_failed++; $display("FAIL sat_ones: got %0d exp 15", stall_cnt); end
    tick(1'b0);
  endtask

  // Sequencer and final report
  initial begin
    drive_idle();
    rst_n = 1'b0;
    #1;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch();
`ifdef EX_CTRL_MC_EN
    test_mc_op();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid_wait();
`else
    test_mc_disabled();
`endif
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
